// File: rtl/nbody_host_if_if.sv
// Host bus bundle for the n-body accelerator front end: chipselect/read/write strobes,
// 16-bit address, 64-bit write data and registered read data.
interface nbody_host_if_if;
  logic        chipselect;
  logic        read;
  logic        write;
  logic [15:0] addr;
  logic [63:0] writedata;
  logic [63:0] readdata;

  modport master (output chipselect, read, write, addr, writedata, input readdata);
  modport slave  (input chipselect, read, write, addr, writedata, output readdata);
endinterface

// File: rtl/nbody_host_if.sv
// Host bus responder for the n-body core: run config, body loads, GO/DONE sequencing, X/Y readback.
// Optional NBODY_HOSTIF_ERRCNT_EN adds a saturating ignored-access counter at select 0x43.
module nbody_host_if #(
  parameter int BODY_ADDR_WIDTH = 9,
  parameter int MAX_BODIES      = 512
) (
  input  logic                       clk,
  input  logic                       rst,
  nbody_host_if_if.slave             bus,
  output logic [9:0]                 n_bodies,
  output logic [31:0]                gap,
  output logic                       ld_we,
  output logic [2:0]                 ld_sel,
  output logic [BODY_ADDR_WIDTH-1:0] ld_idx,
  output logic [63:0]                ld_data,
  output logic                       go,
  output logic                       rd_mode,
  output logic [BODY_ADDR_WIDTH-1:0] rd_idx,
  input  logic [63:0]                rd_x,
  input  logic [63:0]                rd_y,
  input  logic                       core_done
);
  localparam int SEL_W = 16 - BODY_ADDR_WIDTH;
  localparam logic [SEL_W-1:0] SEL_GO     = SEL_W'(8'h00);
  localparam logic [SEL_W-1:0] SEL_READ   = SEL_W'(8'h01);
  localparam logic [SEL_W-1:0] SEL_NB     = SEL_W'(8'h02);
  localparam logic [SEL_W-1:0] SEL_LD_LO  = SEL_W'(8'h03);
  localparam logic [SEL_W-1:0] SEL_LD_HI  = SEL_W'(8'h07);
  localparam logic [SEL_W-1:0] SEL_GAP    = SEL_W'(8'h08);
  localparam logic [SEL_W-1:0] SEL_DONE   = SEL_W'(8'h40);
  localparam logic [SEL_W-1:0] SEL_RD_X   = SEL_W'(8'h41);
  localparam logic [SEL_W-1:0] SEL_RD_Y   = SEL_W'(8'h42);
  localparam logic [SEL_W-1:0] SEL_ERRCNT = SEL_W'(8'h43);

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE, ST_READOUT} state_t;
  typedef enum logic [1:0] {SRC_IMM, SRC_X, SRC_Y} src_t;

  state_t state_reg, state_next;

  logic [SEL_W-1:0]           sel;
  logic [BODY_ADDR_WIDTH-1:0] idx;
  logic [63:0]                wd;
  logic wr_acc, rd_acc, collide;
  logic wr_go, wr_read, wr_nb, wr_gap, wr_load, wr_err;
  logic start_ok, start, illegal, cfg_ok, load_ok;
  logic [9:0]  nb_clamped;
  logic [15:0] errcnt;

  logic [9:0]                 n_bodies_reg;
  logic [31:0]                gap_reg;
  logic                       ld_we_reg;
  logic [2:0]                 ld_sel_reg;
  logic [BODY_ADDR_WIDTH-1:0] ld_idx_reg;
  logic [63:0]                ld_data_reg;
  logic                       go_reg;
  logic                       done_flag_reg;
  logic [BODY_ADDR_WIDTH-1:0] rd_idx_reg;
  logic [63:0]                readdata_reg;

  // First stage of the two-cycle read pipeline: what to return and from where.
  logic        s1_valid_reg;
  src_t        s1_src_reg, rd_src;
  logic [63:0] s1_imm_reg, rd_imm;

  assign sel = bus.addr[15:BODY_ADDR_WIDTH];
  assign idx = bus.addr[BODY_ADDR_WIDTH-1:0];
  assign wd  = bus.writedata;

  // A simultaneous read and write is treated as a write; the read is dropped.
  assign wr_acc  = bus.chipselect & bus.write;
  assign rd_acc  = bus.chipselect & bus.read & ~bus.write;
  assign collide = bus.chipselect & bus.read & bus.write;

  assign wr_go    = wr_acc && (sel == SEL_GO);
  assign wr_read  = wr_acc && (sel == SEL_READ);
  assign wr_nb    = wr_acc && (sel == SEL_NB);
  assign wr_gap   = wr_acc && (sel == SEL_GAP);
  assign wr_load  = wr_acc && (sel >= SEL_LD_LO) && (sel <= SEL_LD_HI);
  assign wr_err   = wr_acc && (sel == SEL_ERRCNT);
  assign start_ok = wr_go && wd[0] && (n_bodies_reg != 10'd0);

  assign cfg_ok  = (state_reg != ST_RUN);
  assign load_ok = (state_reg == ST_IDLE) || (state_reg == ST_DONE);

  assign nb_clamped = (wd > 64'(MAX_BODIES)) ? 10'(MAX_BODIES) : wd[9:0];

  always_ff @(posedge clk) begin
    if (rst) state_reg <= ST_IDLE;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    start      = 1'b0;
    illegal    = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        illegal = wr_read;
        if (start_ok) begin
          state_next = ST_RUN;
          start      = 1'b1;
        end
      end
      ST_RUN: begin
        illegal = wr_go | wr_read | wr_nb | wr_gap | wr_load;
        if (core_done) state_next = ST_DONE;
      end
      ST_DONE: begin
        if (start_ok) begin
          state_next = ST_RUN;
          start      = 1'b1;
        end else if (wr_read && wd[0]) begin
          state_next = ST_READOUT;
        end
      end
      ST_READOUT: begin
        // The reader owns the core memories here, so body loads are refused.
        illegal = wr_load;
        if (start_ok) begin
          state_next = ST_RUN;
          start      = 1'b1;
        end else if (wr_read && !wd[0]) begin
          state_next = ST_DONE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    rd_src = SRC_IMM;
    rd_imm = 64'd0;
    case (sel)
      SEL_DONE:   rd_imm = {63'd0, done_flag_reg};
      SEL_RD_X:   if (state_reg == ST_READOUT) rd_src = SRC_X;
      SEL_RD_Y:   if (state_reg == ST_READOUT) rd_src = SRC_Y;
      SEL_ERRCNT: rd_imm = {48'd0, errcnt};
      default:    rd_imm = 64'd0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      n_bodies_reg  <= '0;
      gap_reg       <= '0;
      ld_we_reg     <= 1'b0;
      ld_sel_reg    <= '0;
      ld_idx_reg    <= '0;
      ld_data_reg   <= '0;
      go_reg        <= 1'b0;
      done_flag_reg <= 1'b0;
      rd_idx_reg    <= '0;
      readdata_reg  <= '0;
      s1_valid_reg  <= 1'b0;
      s1_src_reg    <= SRC_IMM;
      s1_imm_reg    <= '0;
    end else begin
      go_reg    <= start;
      ld_we_reg <= wr_load && load_ok;
      if (wr_load && load_ok) begin
        ld_sel_reg  <= 3'(sel - SEL_LD_LO);
        ld_idx_reg  <= idx;
        ld_data_reg <= wd;
      end
      if (wr_nb && cfg_ok)  n_bodies_reg <= nb_clamped;
      if (wr_gap && cfg_ok) gap_reg      <= wd[31:0];
      if (start)                                  done_flag_reg <= 1'b0;
      else if (state_reg == ST_RUN && core_done)  done_flag_reg <= 1'b1;

      s1_valid_reg <= rd_acc;
      s1_src_reg   <= rd_src;
      s1_imm_reg   <= rd_imm;
      if (rd_acc && (sel == SEL_RD_X || sel == SEL_RD_Y)) rd_idx_reg <= idx;
      // Core memory data is valid the cycle after rd_idx moves.
      if (s1_valid_reg) begin
        case (s1_src_reg)
          SRC_X:   readdata_reg <= rd_x;
          SRC_Y:   readdata_reg <= rd_y;
          default: readdata_reg <= s1_imm_reg;
        endcase
      end
    end
  end

`ifdef NBODY_HOSTIF_ERRCNT_EN
  logic [15:0] errcnt_reg;

  always_ff @(posedge clk) begin
    if (rst || wr_err)                                errcnt_reg <= '0;
    else if ((illegal || collide) && errcnt_reg != 16'hFFFF) errcnt_reg <= errcnt_reg + 16'd1;
  end

  assign errcnt = errcnt_reg;
`else
  logic errcnt_unused;

  assign errcnt        = 16'd0;
  assign errcnt_unused = illegal | collide | wr_err;
`endif

  assign n_bodies     = n_bodies_reg;
  assign gap          = gap_reg;
  assign ld_we        = ld_we_reg;
  assign ld_sel       = ld_sel_reg;
  assign ld_idx       = ld_idx_reg;
  assign ld_data      = ld_data_reg;
  assign go           = go_reg;
  assign rd_mode      = (state_reg == ST_READOUT);
  assign rd_idx       = rd_idx_reg;
  assign bus.readdata = readdata_reg;
endmodule

// File: tb/tb_nbody_host_if.sv
// Scoreboard bench for nbody_host_if: directed scenarios plus random bus traffic checked
// against a behavioural model of the register map and run sequencing.
`timescale 1ns/1ps
module tb_nbody_host_if;
  localparam int BAW = 9;
  localparam int M_IDLE = 0, M_RUN = 1, M_DONE = 2, M_READOUT = 3;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [9:0]     n_bodies;
  logic [31:0]    gap;
  logic           ld_we;
  logic [2:0]     ld_sel;
  logic [BAW-1:0] ld_idx;
  logic [63:0]    ld_data;
  logic           go;
  logic           rd_mode;
  logic [BAW-1:0] rd_idx;
  logic [63:0]    rd_x, rd_y;
  logic           core_done = 1'b0;

  logic [63:0] mem_x [512];
  logic [63:0] mem_y [512];

  nbody_host_if_if bus();

  nbody_host_if #(.BODY_ADDR_WIDTH(BAW), .MAX_BODIES(512)) dut (
    .clk(clk), .rst(rst), .bus(bus),
    .n_bodies(n_bodies), .gap(gap),
    .ld_we(ld_we), .ld_sel(ld_sel), .ld_idx(ld_idx), .ld_data(ld_data),
    .go(go), .rd_mode(rd_mode), .rd_idx(rd_idx),
    .rd_x(rd_x), .rd_y(rd_y), .core_done(core_done)
  );

  always #5 clk = ~clk;

  // Core memories answer combinationally from rd_idx.
  assign rd_x = mem_x[rd_idx];
  assign rd_y = mem_y[rd_idx];

  typedef struct { int due; logic [63:0] val; } rd_exp_t;
  typedef struct { int due; logic [2:0] sel; logic [BAW-1:0] idx; logic [63:0] data; } ld_exp_t;
  rd_exp_t rdq[$];
  ld_exp_t ldq[$];
  int      goq[$];

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Reference model state
  int             mode = M_IDLE;
  logic           done_m = 1'b0;
  logic [9:0]     nb_m = '0;
  logic [31:0]    gap_m = '0;
  logic [BAW-1:0] rdidx_m = '0;
  int             err_m = 0;
  logic [63:0]    last_rd = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%h expected 0x%h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic flag(input string name);
    checks++;
    errors++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endtask

  // Monitor: pops scoreboard entries as outputs appear, tracks steady-state outputs.
  always @(negedge clk) begin
    if (!rst) begin
      while (rdq.size() > 0 && rdq[0].due < cyc) begin
        flag("readdata_stale");
        void'(rdq.pop_front());
      end
      if (rdq.size() > 0 && rdq[0].due == cyc) begin
        chk("readdata", bus.readdata, rdq[0].val);
        last_rd = rdq[0].val;
        void'(rdq.pop_front());
      end else begin
        chk("readdata_hold", bus.readdata, last_rd);
      end

      if (ld_we) begin
        if (ldq.size() == 0 || ldq[0].due != cyc) flag("ld_we_unexpected");
        else begin
          chk("ld_sel", 64'(ld_sel), 64'(ldq[0].sel));
          chk("ld_idx", 64'(ld_idx), 64'(ldq[0].idx));
          chk("ld_data", ld_data, ldq[0].data);
          void'(ldq.pop_front());
        end
      end else if (ldq.size() > 0 && ldq[0].due <= cyc) begin
        flag("ld_we_missing");
        void'(ldq.pop_front());
      end

      if (go) begin
        if (goq.size() == 0 || goq[0] != cyc) flag("go_unexpected");
        else begin
          checks++;
          void'(goq.pop_front());
        end
      end else if (goq.size() > 0 && goq[0] <= cyc) begin
        flag("go_missing");
        void'(goq.pop_front());
      end

      chk("n_bodies", 64'(n_bodies), 64'(nb_m));
      chk("gap", 64'(gap), 64'(gap_m));
      chk("rd_mode", 64'(rd_mode), 64'(mode == M_READOUT));
      chk("rd_idx", 64'(rd_idx), 64'(rdidx_m));
    end
  end

  task automatic err_inc();
    if (err_m < 65535) err_m++;
  endtask

  // Apply one bus access to the model, as seen at the clock edge just taken (cycle cyc).
  task automatic model_access(input bit cs, input bit rd, input bit wr,
                              input logic [6:0] sel, input logic [BAW-1:0] idx, input logic [63:0] d);
    logic [63:0] v;
    if (cs && rd && wr) err_inc();
    if (cs && wr) begin
      case (sel)
        7'h00: if (mode == M_RUN) err_inc();
               else if (d[0] && nb_m != 0) begin
                 mode = M_RUN; done_m = 1'b0; goq.push_back(cyc);
               end
        7'h01: if (mode == M_RUN || mode == M_IDLE) err_inc();
               else if (mode == M_DONE && d[0]) mode = M_READOUT;
               else if (mode == M_READOUT && !d[0]) mode = M_DONE;
        7'h02: if (mode == M_RUN) err_inc();
               else nb_m = (d > 64'd512) ? 10'd512 : d[9:0];
        7'h03, 7'h04, 7'h05, 7'h06, 7'h07:
               if (mode == M_RUN || mode == M_READOUT) err_inc();
               else ldq.push_back('{due: cyc, sel: 3'(sel - 7'd3), idx: idx, data: d});
        7'h08: if (mode == M_RUN) err_inc();
               else gap_m = d[31:0];
`ifdef NBODY_HOSTIF_ERRCNT_EN
        7'h43: err_m = 0;
`endif
        default: ;
      endcase
    end else if (cs && rd) begin
      v = 64'd0;
      case (sel)
        7'h40: v = {63'd0, done_m};
        7'h41: begin rdidx_m = idx; if (mode == M_READOUT) v = mem_x[idx]; end
        7'h42: begin rdidx_m = idx; if (mode == M_READOUT) v = mem_y[idx]; end
`ifdef NBODY_HOSTIF_ERRCNT_EN
        7'h43: v = 64'(err_m);
`endif
        default: v = 64'd0;
      endcase
      rdq.push_back('{due: cyc + 1, val: v});
    end
  endtask

  task automatic access(input bit cs, input bit rd, input bit wr, input int sel, input int idx,
                        input logic [63:0] d);
    bus.chipselect = cs;
    bus.read       = rd;
    bus.write      = wr;
    bus.addr       = {7'(sel), BAW'(idx)};
    bus.writedata  = d;
    @(posedge clk); #1;
    model_access(cs, rd, wr, 7'(sel), BAW'(idx), d);
    bus.chipselect = 1'b0;
    bus.read       = 1'b0;
    bus.write      = 1'b0;
  endtask

  task automatic wr(input int sel, input int idx, input logic [63:0] d);
    access(1'b1, 1'b0, 1'b1, sel, idx, d);
  endtask

  task automatic rd(input int sel, input int idx);
    access(1'b1, 1'b1, 1'b0, sel, idx, 64'd0);
  endtask

  task automatic idle();
    @(posedge clk); #1;
  endtask

  task automatic pulse_done();
    core_done = 1'b1;
    @(posedge clk); #1;
    if (mode == M_RUN) begin
      mode = M_DONE; done_m = 1'b1;
    end
    core_done = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    mode = M_IDLE; done_m = 1'b0; nb_m = '0; gap_m = '0; rdidx_m = '0; err_m = 0;
    rdq.delete(); ldq.delete(); goq.delete();
    last_rd = '0;
    rst = 1'b0;
  endtask

  task automatic check_reset_outputs();
    @(negedge clk);
    chk("rst_readdata", bus.readdata, 64'd0);
    chk("rst_go", 64'(go), 64'd0);
    chk("rst_ld_we", 64'(ld_we), 64'd0);
    chk("rst_ld_sel", 64'(ld_sel), 64'd0);
    chk("rst_ld_idx", 64'(ld_idx), 64'd0);
    chk("rst_ld_data", ld_data, 64'd0);
    chk("rst_rd_mode", 64'(rd_mode), 64'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    int r, pick, s, rw;
    bit cs_b, rd_b, wr_b;
    logic [63:0] d;

    bus.chipselect = 1'b0; bus.read = 1'b0; bus.write = 1'b0;
    bus.addr = '0; bus.writedata = '0;
    for (int i = 0; i < 512; i++) begin
      mem_x[i] = {$urandom, $urandom};
      mem_y[i] = {$urandom, $urandom};
    end
    mem_x[2] = 64'h4034000000000000;

    @(posedge clk);
    do_reset();
    check_reset_outputs();

    // Configuration and first body load
    wr(8'h02, 0, 64'd21);
    wr(8'h08, 0, 64'd2);
    wr(8'h03, 0, 64'h3FF0000000000000);
    idle();
    wr(8'h02, 0, 64'd1000);
    wr(8'h02, 0, 64'd0);
    wr(8'h00, 0, 64'd1);
    rd(8'h40, 0);
    wr(8'h02, 0, 64'd21);
    wr(8'h06, 17, {$urandom, $urandom});
    wr(8'h07, 511, {$urandom, $urandom});

    // Run: GO, writes ignored, done status
    wr(8'h00, 0, 64'd1);
    wr(8'h03, 4, 64'h1234);
    wr(8'h08, 0, 64'd99);
    wr(8'h02, 0, 64'd7);
    rd(8'h40, 0);
    rd(8'h43, 0);
    idle();
    pulse_done();
    rd(8'h40, 0);

    // Readback
    wr(8'h01, 0, 64'd1);
    rd(8'h41, 2);
    rd(8'h42, 2);
    rd(8'h41, 300);
    access(1'b0, 1'b1, 1'b0, 8'h42, 5, 64'd0);
    access(1'b1, 1'b1, 1'b1, 8'h08, 0, 64'd7);
    wr(8'h04, 3, 64'd55);
    rd(8'h43, 0);
    wr(8'h01, 0, 64'd0);
    rd(8'h42, 9);
    rd(8'h55, 1);
    idle();
    idle();

    // Random traffic
    for (int i = 0; i < 900; i++) begin
      r = $urandom_range(0, 99);
      if (r < 8) idle();
      else if (r < 16) pulse_done();
      else begin
        pick = $urandom_range(0, 13);
        if (pick <= 8) s = pick;
        else if (pick <= 12) s = 8'h40 + pick - 9;
        else s = $urandom_range(0, 127);
        d = {$urandom, $urandom};
        if (s == 0 || s == 1) d = 64'($urandom_range(0, 3) != 0);
        if (s == 2 && $urandom_range(0, 3) != 0) d = 64'($urandom_range(0, 40));
        cs_b = ($urandom_range(0, 9) != 0);
        rw = $urandom_range(0, 9);
        rd_b = (rw >= 4);
        wr_b = (rw < 4) || (rw >= 8);
        access(cs_b, rd_b, wr_b, s, $urandom_range(0, 511), d);
      end
    end
    idle();
    idle();

    // Reset in the middle of a run, then confirm IDLE behaviour
    do_reset();
    wr(8'h02, 0, 64'd5);
    wr(8'h00, 0, 64'd1);
    rd(8'h41, 7);
    do_reset();
    check_reset_outputs();
    wr(8'h00, 0, 64'd1);
    wr(8'h05, 8, 64'hC000000000000000);
    rd(8'h40, 0);
    idle();
    idle();
    idle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
